cart_mbc1: RTL and testbench

//  Cartridge-side responder for the console bus (a/din/rd/wr), emulating an MBC1 mapper in fabric.

---
 rtl/cart_pkg.sv | 45 ++++
 rtl/cart_bus_sync.sv | 30 +++
 rtl/cart_mbc1.sv | 166 ++++++++++++++++
 tb/tb_cart_mbc1.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared constants and address-mapping helpers for the MBC1 cartridge responder.
// Define MBC1_MULTICART_EN for MBC1M wiring (4-bit bank1, bank2 shifted by 4).
package cart_pkg;

   localparam logic [15:0] REG_RAMEN = 16'h0000;
   localparam logic [15:0] REG_BANK1 = 16'h2000;
   localparam logic [15:0] REG_BANK2 = 16'h4000;
   localparam logic [15:0] REG_MODE  = 16'h6000;
   localparam logic [15:0] RAM_BASE  = 16'hA000;

   localparam logic [7:0] OPEN_BUS = 8'hFF;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRIVE = 2'd3;

   // Bank 0 is never selectable through bank1; writing it selects bank 1.
   function automatic logic [4:0] bank1Value(input logic [4:0] din);
`ifdef MBC1_MULTICART_EN
      return (din[3:0] == 4'd0) ? 5'd1 : {1'b0, din[3:0]};
`else
      return (din == 5'd0) ? 5'd1 : din;
`endif
   endfunction

   function automatic logic [20:0] mapRom(input logic [14:0] a, input logic [4:0] bank1,
                                          input logic [1:0] bank2, input logic mode);
      logic [6:0] bank;
`ifdef MBC1_MULTICART_EN
      if (a[14]) bank = {1'b0, bank2, bank1[3:0]};
      else       bank = mode ? {1'b0, bank2, 4'd0} : 7'd0;
`else
      if (a[14]) bank = {bank2, bank1};
      else       bank = mode ? {bank2, 5'd0} : 7'd0;
`endif
      return {bank, a[13:0]};
   endfunction

   function automatic logic [14:0] mapRam(input logic [12:0] a, input logic [1:0] bank2,
                                          input logic mode);
      return {(mode ? bank2 : 2'd0), a};
   endfunction

endpackage

// File: rtl/cart_bus_sync.sv
// Synchroniser for one console strobe, with single-cycle rising/falling edge pulses.
module cart_bus_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] chain_q;
   logic              last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
         last_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], strobe_i};
         last_q  <= chain_q[STAGES-1];
      end
   end

   assign sync_o = chain_q[STAGES-1];
   assign rise_o = chain_q[STAGES-1] & ~last_q;
   assign fall_o = ~chain_q[STAGES-1] & last_q;

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge responder: decodes console register writes and maps reads onto ROM/RAM ports.
// Define MBC1_MULTICART_EN to build the MBC1M (multicart) bank wiring.
module cart_mbc1
   import cart_pkg::*;
#(
   parameter int ROM_ADDR_W  = 21,
   parameter int RAM_ADDR_W  = 15,
   parameter int MEM_LATENCY = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           gb_a,
   input  logic [7:0]            gb_din,
   input  logic                  gb_rd,
   input  logic                  gb_wr,
   output logic [7:0]            cart_dout,
   output logic                  cart_oe,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   output logic                  rom_rd,
   input  logic [7:0]            rom_data,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic                  ram_rd,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_data
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   logic rdSync, rdRise, rdFall, wrSync, wrRise, wrFall;
   logic unusedStrobes;

   cart_bus_sync #(.STAGES(SYNC_STAGES)) uRdSync (
      .clk(clk), .rst(rst), .strobe_i(gb_rd),
      .sync_o(rdSync), .rise_o(rdRise), .fall_o(rdFall)
   );

   cart_bus_sync #(.STAGES(SYNC_STAGES)) uWrSync (
      .clk(clk), .rst(rst), .strobe_i(gb_wr),
      .sync_o(wrSync), .rise_o(wrRise), .fall_o(wrFall)
   );

   assign unusedStrobes = rdFall ^ wrSync ^ wrFall;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  isRam_q, isRam_d;
   logic                  ramEn_q, ramEn_d;
   logic [4:0]            bank1_q, bank1_d;
   logic [1:0]            bank2_q, bank2_d;
   logic                  mode_q, mode_d;
   logic [ROM_ADDR_W-1:0] romAddr_q, romAddr_d;
   logic [RAM_ADDR_W-1:0] ramAddr_q, ramAddr_d;
   logic [7:0]            ramWdata_q, ramWdata_d;
   logic                  ramWe_q, ramWe_d;
   logic [7:0]            dout_q, dout_d;
   logic                  readOwned;

   assign readOwned = (gb_a[15] == 1'b0) || (gb_a[15:13] == RAM_BASE[15:13]);

   // Writes act in every state; a read is accepted only from IDLE and loses to a simultaneous write.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      isRam_d    = isRam_q;
      ramEn_d    = ramEn_q;
      bank1_d    = bank1_q;
      bank2_d    = bank2_q;
      mode_d     = mode_q;
      romAddr_d  = romAddr_q;
      ramAddr_d  = ramAddr_q;
      ramWdata_d = ramWdata_q;
      ramWe_d    = 1'b0;
      dout_d     = dout_q;

      if (wrRise) begin
         case (gb_a[15:13])
            REG_RAMEN[15:13]: ramEn_d = (gb_din[3:0] == 4'hA);
            REG_BANK1[15:13]: bank1_d = bank1Value(gb_din[4:0]);
            REG_BANK2[15:13]: bank2_d = gb_din[1:0];
            REG_MODE[15:13]:  mode_d  = gb_din[0];
            RAM_BASE[15:13]: begin
               if (ramEn_q) begin
                  ramWe_d    = 1'b1;
                  ramAddr_d  = RAM_ADDR_W'(mapRam(gb_a[12:0], bank2_q, mode_q));
                  ramWdata_d = gb_din;
               end
            end
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (rdRise && !wrRise && readOwned) begin
               state_d = ST_FETCH;
               isRam_d = gb_a[15];
               if (gb_a[15]) ramAddr_d = RAM_ADDR_W'(mapRam(gb_a[12:0], bank2_q, mode_q));
               else          romAddr_d = ROM_ADDR_W'(mapRom(gb_a[14:0], bank1_q, bank2_q, mode_q));
            end
         end
         ST_FETCH: begin
            cnt_d = '0;
            if (isRam_q && !ramEn_q) begin
               dout_d  = OPEN_BUS;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               dout_d  = isRam_q ? ram_data : rom_data;
               state_d = ST_DRIVE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (!rdSync) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         isRam_q    <= 1'b0;
         ramEn_q    <= 1'b0;
         bank1_q    <= 5'd1;
         bank2_q    <= 2'd0;
         mode_q     <= 1'b0;
         romAddr_q  <= '0;
         ramAddr_q  <= '0;
         ramWdata_q <= '0;
         ramWe_q    <= 1'b0;
         dout_q     <= OPEN_BUS;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         isRam_q    <= isRam_d;
         ramEn_q    <= ramEn_d;
         bank1_q    <= bank1_d;
         bank2_q    <= bank2_d;
         mode_q     <= mode_d;
         romAddr_q  <= romAddr_d;
         ramAddr_q  <= ramAddr_d;
         ramWdata_q <= ramWdata_d;
         ramWe_q    <= ramWe_d;
         dout_q     <= dout_d;
      end
   end

   assign cart_oe   = (state_q == ST_DRIVE);
   assign cart_dout = dout_q;
   assign rom_addr  = romAddr_q;
   assign rom_rd    = (state_q == ST_FETCH) && !isRam_q;
   assign ram_addr  = ramAddr_q;
   assign ram_rd    = (state_q == ST_FETCH) && isRam_q && ramEn_q;
   assign ram_we    = ramWe_q;
   assign ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_cart_mbc1.sv
// Randomised self-checking bench for cart_mbc1 against a behavioural MBC1 model.
// Builds for either MBC1_MULTICART_EN setting; the reference model follows the same macro.
module tb_cart_mbc1;

   localparam int SYNC = 2;
   localparam int LAT  = 2;
   localparam int READ_LAT = SYNC + 2 + LAT;
`ifdef MBC1_MULTICART_EN
   localparam int BANK1_MOD = 16;
   localparam int BANK2_MUL = 16;
`else
   localparam int BANK1_MOD = 32;
   localparam int BANK2_MUL = 32;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] gb_a = '0;
   logic [7:0]  gb_din = '0;
   logic        gb_rd = 1'b0;
   logic        gb_wr = 1'b0;
   logic [7:0]  cart_dout;
   logic        cart_oe;
   logic [20:0] rom_addr;
   logic        rom_rd;
   logic [7:0]  rom_data;
   logic [14:0] ram_addr;
   logic        ram_rd;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_data;

   int checks = 0;
   int errors = 0;

   cart_mbc1 #(.ROM_ADDR_W(21), .RAM_ADDR_W(15), .MEM_LATENCY(LAT), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .gb_a(gb_a), .gb_din(gb_din), .gb_rd(gb_rd), .gb_wr(gb_wr),
      .cart_dout(cart_dout), .cart_oe(cart_oe), .rom_addr(rom_addr), .rom_rd(rom_rd),
      .rom_data(rom_data), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   // Storage model: data appears LAT cycles after the fetch pulse, junk otherwise.
   function automatic logic [7:0] romByte(input logic [20:0] a);
      return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
   endfunction

   logic        romV1 = 1'b0, romV2 = 1'b0, ramV1 = 1'b0, ramV2 = 1'b0;
   logic [20:0] romA1 = '0, romA2 = '0;
   logic [14:0] ramA1 = '0, ramA2 = '0;
   logic [7:0]  ramMem [32768] = '{default: 8'h00};

   always @(posedge clk) begin
      romV1 <= rom_rd;  romV2 <= romV1;
      romA1 <= rom_addr; romA2 <= romA1;
      ramV1 <= ram_rd;  ramV2 <= ramV1;
      ramA1 <= ram_addr; ramA2 <= ramA1;
      if (ram_we) ramMem[ram_addr] <= ram_wdata;
   end

   assign rom_data = romV2 ? romByte(romA2) : 8'hEE;
   assign ram_data = ramV2 ? ramMem[ramA2] : 8'hEE;

   // Reference model of the mapper registers and cartridge RAM contents.
   int       refBank1 = 1, refBank2 = 0, refMode = 0;
   bit       refRamEn = 1'b0;
   logic [7:0] refRam [32768] = '{default: 8'h00};

   function automatic int refRomAddr(input int a);
      int bank;
      if (a < 'h4000) bank = (refMode != 0) ? refBank2 * BANK2_MUL : 0;
      else            bank = refBank2 * BANK2_MUL + refBank1;
      return (bank * 16384 + (a % 16384)) % (1 << 21);
   endfunction

   function automatic int refRamAddr(input int a);
      return ((refMode != 0) ? refBank2 : 0) * 8192 + (a % 8192);
   endfunction

   function automatic bit isOwnedRead(input int a);
      return (a < 'h8000) || (a >= 'hA000 && a < 'hC000);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic refWrite(input int a, input int d);
      if (a < 'h2000)      refRamEn = ((d % 16) == 'hA);
      else if (a < 'h4000) begin
         refBank1 = d % BANK1_MOD;
         if (refBank1 == 0) refBank1 = 1;
      end
      else if (a < 'h6000) refBank2 = d % 4;
      else if (a < 'h8000) refMode = d % 2;
   endtask

   // One console bus cycle: a write when isWrite, otherwise a read held until the cart drives.
   task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [7:0] data);
      int pulses, lat, romP, ramP, drop, expLat;
      logic [31:0] capAddr, capData;
      bit isRam;
      pulses = 0; lat = 0; romP = 0; ramP = 0; drop = 0;
      capAddr = '0; capData = '0;
      isRam = (addr >= 16'hA000 && addr < 16'hC000);
      @(negedge clk);
      gb_a = addr;
      if (isWrite) begin
         gb_din = data;
         gb_wr = 1'b1;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ram_we) begin
               pulses++;
               capAddr = 32'(ram_addr);
               capData = 32'(ram_wdata);
            end
         end
         @(negedge clk); gb_wr = 1'b0;
         repeat (3) @(negedge clk);
         checkOutput("ram_we pulses", 32'(pulses), (isRam && refRamEn) ? 32'd1 : 32'd0);
         if (isRam && refRamEn) begin
            checkOutput("ram_we addr", capAddr, 32'(refRamAddr(int'(addr))));
            checkOutput("ram_we data", capData, 32'(data));
            refRam[refRamAddr(int'(addr))] = data;
         end
         refWrite(int'(addr), int'(data));
         return;
      end
      gb_rd = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (rom_rd) begin romP++; capAddr = 32'(rom_addr); end
         if (ram_rd) begin ramP++; capAddr = 32'(ram_addr); end
         if (cart_oe) begin lat = i; break; end
      end
      if (!isOwnedRead(int'(addr))) begin
         checkOutput("unowned oe", 32'(lat), 32'd0);
         checkOutput("unowned fetch", 32'(romP + ramP), 32'd0);
         @(negedge clk); gb_rd = 1'b0;
         repeat (3) @(negedge clk);
         return;
      end
      expLat = (isRam && !refRamEn) ? SYNC + 2 : READ_LAT;
      checkOutput("read latency", 32'(lat), 32'(expLat));
      if (!isRam) begin
         checkOutput("rom_rd pulses", 32'(romP + ramP), 32'd1);
         checkOutput("rom_addr", capAddr, 32'(refRomAddr(int'(addr))));
         checkOutput("rom dout", 32'(cart_dout), 32'(romByte(21'(refRomAddr(int'(addr))))));
      end else begin
         checkOutput("ram_rd pulses", 32'(romP + ramP), refRamEn ? 32'd1 : 32'd0);
         if (refRamEn) begin
            checkOutput("ram_addr", capAddr, 32'(refRamAddr(int'(addr))));
            checkOutput("ram dout", 32'(cart_dout), 32'(refRam[refRamAddr(int'(addr))]));
         end else begin
            checkOutput("ram dout disabled", 32'(cart_dout), 32'hFF);
         end
      end
      // Moving the address while rd stays high must not trigger another fetch.
      @(negedge clk); gb_a = addr ^ 16'h0100;
      romP = 0; ramP = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (rom_rd || ram_rd) romP++;
      end
      checkOutput("no refetch", 32'(romP), 32'd0);
      checkOutput("oe held", 32'(cart_oe), 32'd1);
      @(negedge clk); gb_rd = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (!cart_oe) begin drop = i; break; end
      end
      checkOutput("oe release", 32'(drop), 32'(SYNC + 1));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int r, hit;
      logic [15:0] a;
      logic [7:0] d;
      logic [31:0] capAddr;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset dout", 32'(cart_dout), 32'hFF);
      checkOutput("reset oe", 32'(cart_oe), 32'd0);
      checkOutput("reset strobes", 32'({rom_rd, ram_rd, ram_we}), 32'd0);
      checkOutput("reset addrs", 32'(rom_addr) | 32'(ram_addr), 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(1'b0, 16'h0150, 8'h00);
      applyStimulus(1'b1, 16'h2000, 8'h00);
      applyStimulus(1'b0, 16'h4000, 8'h00);
      applyStimulus(1'b1, 16'h2000, 8'h13);
      applyStimulus(1'b0, 16'h7FFF, 8'h00);
      applyStimulus(1'b1, 16'h4000, 8'h02);
      applyStimulus(1'b1, 16'h6000, 8'h01);
      applyStimulus(1'b0, 16'h0000, 8'h00);
      applyStimulus(1'b1, 16'h6000, 8'h00);
      applyStimulus(1'b0, 16'h0000, 8'h00);
      applyStimulus(1'b1, 16'hA000, 8'h55);
      applyStimulus(1'b1, 16'h0000, 8'h0A);
      applyStimulus(1'b1, 16'hA123, 8'h55);
      applyStimulus(1'b0, 16'hA123, 8'h00);
      applyStimulus(1'b1, 16'h0000, 8'h00);
      applyStimulus(1'b0, 16'hA000, 8'h00);
      applyStimulus(1'b1, 16'h2000, 8'h1F);
      applyStimulus(1'b1, 16'h4000, 8'h01);
      applyStimulus(1'b0, 16'h4000, 8'h00);
      applyStimulus(1'b0, 16'hC000, 8'h00);

      // Simultaneous rd and wr edges: the write wins and the read is dropped.
      @(negedge clk);
      gb_a = 16'h2000; gb_din = 8'h03; gb_rd = 1'b1; gb_wr = 1'b1;
      hit = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rom_rd || cart_oe) hit++;
      end
      checkOutput("rd dropped on wr", 32'(hit), 32'd0);
      @(negedge clk); gb_rd = 1'b0; gb_wr = 1'b0;
      refWrite('h2000, 'h03);
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 16'h4ABC, 8'h00);

      // Bank write while a read is in flight keeps the already-mapped address.
      @(negedge clk);
      gb_a = 16'h5000; gb_rd = 1'b1;
      capAddr = '0; hit = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rom_rd) begin capAddr = 32'(rom_addr); break; end
      end
      @(negedge clk);
      gb_a = 16'h2000; gb_din = 8'h07; gb_wr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (cart_oe) begin hit = 1; break; end
      end
      checkOutput("inflight oe", 32'(hit), 32'd1);
      checkOutput("inflight addr", capAddr, 32'(refRomAddr('h5000)));
      checkOutput("inflight dout", 32'(cart_dout), 32'(romByte(21'(refRomAddr('h5000)))));
      @(negedge clk); gb_rd = 1'b0; gb_wr = 1'b0;
      refWrite('h2000, 'h07);
      repeat (5) @(negedge clk);
      checkOutput("inflight idle", 32'(cart_oe), 32'd0);
      applyStimulus(1'b0, 16'h5000, 8'h00);

      for (int n = 0; n < 90; n++) begin
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         case (r)
            0: applyStimulus(1'b1, 16'h0000 + 16'($urandom_range(0, 'h1FFF)),
                             ($urandom_range(0, 2) != 0) ? 8'h0A : d);
            1: applyStimulus(1'b1, 16'h2000 + 16'($urandom_range(0, 'h1FFF)), d);
            2: applyStimulus(1'b1, 16'h4000 + 16'($urandom_range(0, 'h1FFF)), d);
            3: applyStimulus(1'b1, 16'h6000 + 16'($urandom_range(0, 'h1FFF)), d);
            4, 5: applyStimulus(1'b1, 16'hA000 + 16'($urandom_range(0, 'h1FFF)), d);
            6, 7: applyStimulus(1'b0, 16'($urandom_range(0, 'h7FFF)), 8'h00);
            8: applyStimulus(1'b0, 16'hA000 + 16'($urandom_range(0, 'h1FFF)), 8'h00);
            default: begin
               a = ($urandom_range(0, 1) != 0) ? 16'h8000 + 16'($urandom_range(0, 'h1FFF))
                                               : 16'hC000 + 16'($urandom_range(0, 'h3FFF));
               applyStimulus($urandom_range(0, 1) != 0, a, d);
            end
         endcase
      end

      // Reset asserted while the cart is driving the bus.
      @(negedge clk);
      gb_a = 16'h0150; gb_rd = 1'b1;
      hit = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (cart_oe) begin hit = 1; break; end
      end
      checkOutput("pre-reset oe", 32'(hit), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset oe", 32'(cart_oe), 32'd0);
      checkOutput("async reset dout", 32'(cart_dout), 32'hFF);
      gb_rd = 1'b0;
      @(negedge clk); rst = 1'b0;
      refRamEn = 1'b0; refBank1 = 1; refBank2 = 0; refMode = 0;
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 16'h4000, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
